// File: rtl/scr1_dbga_mh_pkg.sv
// Multi-hart debug agent: shared types and the halt-cause priority helper.
package scr1_dbga_mh_pkg;

   typedef enum logic [2:0] {
      DBGA_CAUSE_NONE  = 3'd0,
      DBGA_CAUSE_ENF   = 3'd1,
      DBGA_CAUSE_RST   = 3'd2,
      DBGA_CAUSE_BRK   = 3'd3,
      DBGA_CAUSE_SSTEP = 3'd4,
      DBGA_CAUSE_GRP   = 3'd5
   } type_scr1_dbga_cause_e;

   typedef enum logic [1:0] {
      HART_RUN,
      HART_PEND,
      HART_HALTED
   } type_scr1_dbga_hstate_e;

   typedef enum logic [2:0] {
      CMD_IDLE,
      CMD_HALT,
      CMD_RGO,
      CMD_NACK,
      CMD_WAIT
   } type_scr1_dbga_cmd_e;

   function automatic type_scr1_dbga_cause_e dbga_cause_prio(
      input logic rst,
      input logic brk,
      input logic sstep,
      input logic enf,
      input logic grp
   );
      if (rst)        return DBGA_CAUSE_RST;
      else if (brk)   return DBGA_CAUSE_BRK;
      else if (sstep) return DBGA_CAUSE_SSTEP;
      else if (enf)   return DBGA_CAUSE_ENF;
      else if (grp)   return DBGA_CAUSE_GRP;
      else            return DBGA_CAUSE_NONE;
   endfunction

endpackage

// File: rtl/scr1_pipe_dbga_hart.sv
// One hart channel: run/pend/halted FSM, halt-wait timeout and cause latch.
module scr1_pipe_dbga_hart
   import scr1_dbga_mh_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       halt_req,
   input  logic       grp_req,
   input  logic       run_req,
   input  logic       own_rst,
   input  logic       own_brk,
   input  logic       own_sstep,
   input  logic       busy,
   output logic       halted,
   output logic       run2halt,
   output logic       halt2run,
   output logic       no_commit,
   output logic       timeout,
   output logic [2:0] cause
);

   localparam int TO_W = $clog2(TIMEOUT);

   type_scr1_dbga_hstate_e st, st_nx;
   type_scr1_dbga_cause_e  pc, pc_nx, sel, cause_q;
   logic [TO_W-1:0]        cnt, cnt_nx;
   logic                   to_nx;
   logic                   own_any;
   logic                   cnt0;

   assign own_any  = own_rst | own_brk | own_sstep;
   assign cnt0     = (cnt == '0);
   // Kept apart from the next-state block: the group fan-out feeds back on it
   assign run2halt = en & (((st == HART_RUN) & own_any & ~busy)
                   | ((st == HART_PEND) & (~busy | cnt0)));
   assign halt2run = en & (st == HART_HALTED) & run_req;
   assign halted   = (st == HART_HALTED);
   assign cause    = cause_q;

   always_comb begin
      sel = dbga_cause_prio(own_rst, own_brk, own_sstep,
               halt_req | ((st == HART_PEND) & (pc == DBGA_CAUSE_ENF)),
               grp_req  | ((st == HART_PEND) & (pc == DBGA_CAUSE_GRP)));
   end

   assign no_commit = run2halt & (sel == DBGA_CAUSE_BRK);

   always_comb begin
      st_nx  = st;
      pc_nx  = pc;
      cnt_nx = cnt;
      to_nx  = timeout;
      if (en) begin
         unique case (st)
            HART_RUN: begin
               if (run2halt) begin
                  st_nx = HART_HALTED;
               end else if (halt_req | grp_req) begin
                  st_nx = HART_PEND;
                  pc_nx = halt_req ? DBGA_CAUSE_ENF : DBGA_CAUSE_GRP;
               end
            end
            HART_PEND: begin
               if (run2halt) begin
                  st_nx = HART_HALTED;
                  to_nx = busy;
               end else begin
                  cnt_nx = cnt - TO_W'(1);
               end
               if (halt_req) pc_nx = DBGA_CAUSE_ENF;
            end
            HART_HALTED: begin
               if (run_req) begin
                  st_nx  = HART_RUN;
                  cnt_nx = TO_W'(TIMEOUT - 1);
                  to_nx  = 1'b0;
               end
            end
            default: st_nx = HART_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= HART_RUN;
         pc      <= DBGA_CAUSE_NONE;
         cnt     <= TO_W'(TIMEOUT - 1);
         timeout <= 1'b0;
         cause_q <= DBGA_CAUSE_NONE;
      end else begin
         st      <= st_nx;
         pc      <= pc_nx;
         cnt     <= cnt_nx;
         timeout <= to_nx;
         if (run2halt) cause_q <= sel;
      end
   end

endmodule

// File: rtl/scr1_pipe_dbga_mh.sv
// Multi-hart debug agent: DBGC command sequencing and halt-group fan-out.
module scr1_pipe_dbga_mh
   import scr1_dbga_mh_pkg::*;
#(
   parameter int N_HARTS = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clk_pipe_en,
   input  logic                 cmd_req,
   input  logic                 cmd_halt,
   input  logic [N_HARTS-1:0]   cmd_mask,
   output logic                 cmd_ack,
   output logic                 cmd_nack,
   input  logic [N_HARTS-1:0]   grp_en,
   input  logic [N_HARTS-1:0]   dmode_rst_en,
   input  logic [N_HARTS-1:0]   dmode_sstep_en,
   input  logic [N_HARTS-1:0]   dmode_brk_en,
   input  logic [N_HARTS-1:0]   exu_busy,
   input  logic [N_HARTS-1:0]   instret,
   input  logic [N_HARTS-1:0]   brkpt,
   input  logic [N_HARTS-1:0]   exu_init_pc,
   output logic [N_HARTS-1:0]   exu_no_commit,
   output logic [N_HARTS-1:0]   halted,
   output logic [N_HARTS-1:0]   run2halt,
   output logic [N_HARTS-1:0]   halt2run,
   output logic [N_HARTS-1:0]   run_start,
   output logic [N_HARTS-1:0]   timeout,
   output logic [3*N_HARTS-1:0] cause
);

   type_scr1_dbga_cmd_e cs, cs_nx;
   logic [N_HARTS-1:0]  mask_q;
   logic [N_HARTS-1:0]  rs_q;
   logic [N_HARTS-1:0]  own_rst, own_brk, own_sstep;
   logic [N_HARTS-1:0]  grp_src, grp_req;
   logic [N_HARTS-1:0]  halt_req, run_req;
   logic                all_h, q_all_h, q_to;

   assign own_rst   = dmode_rst_en & exu_init_pc;
   assign own_brk   = dmode_brk_en & brkpt;
   assign own_sstep = dmode_sstep_en & instret;
   assign grp_src   = run2halt & (own_rst | own_brk | own_sstep) & grp_en;

   assign all_h   = ((cmd_mask & ~halted) == '0);
   assign q_all_h = ((mask_q & ~halted) == '0);
   assign q_to    = |(mask_q & timeout);

   for (genvar i = 0; i < N_HARTS; i++) begin : g_hart
      assign grp_req[i] = grp_en[i] & |(grp_src & ~(N_HARTS'(1) << i));

      scr1_pipe_dbga_hart #(
         .TIMEOUT (TIMEOUT)
      ) u_hart (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (clk_pipe_en),
         .halt_req  (halt_req[i]),
         .grp_req   (grp_req[i]),
         .run_req   (run_req[i]),
         .own_rst   (own_rst[i]),
         .own_brk   (own_brk[i]),
         .own_sstep (own_sstep[i]),
         .busy      (exu_busy[i]),
         .halted    (halted[i]),
         .run2halt  (run2halt[i]),
         .halt2run  (halt2run[i]),
         .no_commit (exu_no_commit[i]),
         .timeout   (timeout[i]),
         .cause     (cause[3*i +: 3])
      );
   end

   always_comb begin
      cs_nx    = cs;
      cmd_ack  = 1'b0;
      cmd_nack = 1'b0;
      halt_req = '0;
      run_req  = '0;
      if (clk_pipe_en) begin
         unique case (cs)
            CMD_IDLE: begin
               if (cmd_req) begin
                  if (cmd_mask == '0) begin
                     cs_nx = CMD_NACK;
                  end else if (cmd_halt) begin
                     // Halting only already-halted harts is rejected
                     if (all_h) begin
                        cs_nx = CMD_NACK;
                     end else begin
                        cs_nx    = CMD_HALT;
                        halt_req = cmd_mask;
                     end
                  end else begin
                     cs_nx = all_h ? CMD_RGO : CMD_NACK;
                  end
               end
            end
            CMD_HALT: begin
               if (!cmd_req) begin
                  cs_nx = CMD_IDLE;
               end else if (q_all_h) begin
                  cmd_ack  = ~q_to;
                  cmd_nack = q_to;
                  cs_nx    = CMD_WAIT;
               end
            end
            CMD_RGO: begin
               cmd_ack = 1'b1;
               run_req = mask_q;
               cs_nx   = cmd_req ? CMD_WAIT : CMD_IDLE;
            end
            CMD_NACK: begin
               cmd_nack = 1'b1;
               cs_nx    = cmd_req ? CMD_WAIT : CMD_IDLE;
            end
            CMD_WAIT: begin
               if (!cmd_req) cs_nx = CMD_IDLE;
            end
            default: cs_nx = CMD_IDLE;
         endcase
      end
   end

   assign run_start = rs_q & {N_HARTS{clk_pipe_en}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs     <= CMD_IDLE;
         mask_q <= '0;
         rs_q   <= '0;
      end else begin
         cs <= cs_nx;
         if (clk_pipe_en) begin
            rs_q <= halt2run;
            if ((cs == CMD_IDLE) && cmd_req) mask_q <= cmd_mask;
         end
      end
   end

endmodule

// File: tb/tb_scr1_pipe_dbga_mh.sv
// Scoreboard bench for scr1_pipe_dbga_mh: command model plus directed corners.
module tb_scr1_pipe_dbga_mh;

   localparam int N = 2;
   localparam int T = 64;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           clk_pipe_en = 1'b1;
   logic           cmd_req = 1'b0;
   logic           cmd_halt = 1'b0;
   logic [N-1:0]   cmd_mask = '0;
   logic           cmd_ack, cmd_nack;
   logic [N-1:0]   grp_en = '0;
   logic [N-1:0]   dmode_rst_en = '0;
   logic [N-1:0]   dmode_sstep_en = '0;
   logic [N-1:0]   dmode_brk_en = '0;
   logic [N-1:0]   exu_busy = '0;
   logic [N-1:0]   instret = '0;
   logic [N-1:0]   brkpt = '0;
   logic [N-1:0]   exu_init_pc = '0;
   logic [N-1:0]   exu_no_commit, halted, run2halt, halt2run;
   logic [N-1:0]   run_start, timeout;
   logic [3*N-1:0] cause;

   scr1_pipe_dbga_mh #(.N_HARTS(N), .TIMEOUT(T)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clk_pipe_en    (clk_pipe_en),
      .cmd_req        (cmd_req),
      .cmd_halt       (cmd_halt),
      .cmd_mask       (cmd_mask),
      .cmd_ack        (cmd_ack),
      .cmd_nack       (cmd_nack),
      .grp_en         (grp_en),
      .dmode_rst_en   (dmode_rst_en),
      .dmode_sstep_en (dmode_sstep_en),
      .dmode_brk_en   (dmode_brk_en),
      .exu_busy       (exu_busy),
      .instret        (instret),
      .brkpt          (brkpt),
      .exu_init_pc    (exu_init_pc),
      .exu_no_commit  (exu_no_commit),
      .halted         (halted),
      .run2halt       (run2halt),
      .halt2run       (halt2run),
      .run_start      (run_start),
      .timeout        (timeout),
      .cause          (cause)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      bit           ack;
      int           t0;
      int           lat;
      logic [N-1:0] h;
      logic [N-1:0] h2r;
      logic [N-1:0] to;
      logic [3*N-1:0] c;
   } exp_t;

   exp_t q[$];

   // Reference model: per-hart halted flag, sticky timeout, last latched cause
   logic [N-1:0] m_h, m_to;
   logic [2:0]   m_c [N];

   function automatic logic [3*N-1:0] pk();
      logic [3*N-1:0] r;
      for (int i = 0; i < N; i++) r[3*i +: 3] = m_c[i];
      return r;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (cmd_ack || cmd_nack)) begin
            chk("ack_nack_excl", 32'(cmd_ack & cmd_nack), 0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp actual ack=%0b nack=%0b expected none",
                        cmd_ack, cmd_nack);
            end else begin
               e = q.pop_front();
               chk("resp_ack", 32'(cmd_ack), 32'(e.ack));
               chk("resp_nack", 32'(cmd_nack), 32'(!e.ack));
               chk("latency", cyc - e.t0, e.lat);
               chk("halt2run", 32'(halt2run), 32'(e.h2r));
               @(negedge clk);
               chk("halted", 32'(halted), 32'(e.h));
               chk("cause", 32'(cause), 32'(e.c));
               chk("timeout", 32'(timeout), 32'(e.to));
               chk("run_start", 32'(run_start), 32'(e.h2r));
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      cmd_req = 1'b0;
      exu_busy = '0;
      brkpt = '0;
      exu_init_pc = '0;
      instret = '0;
      grp_en = '0;
      dmode_rst_en = '0;
      dmode_brk_en = '0;
      dmode_sstep_en = '0;
      clk_pipe_en = 1'b1;
      m_h = '0;
      m_to = '0;
      for (int i = 0; i < N; i++) m_c[i] = 3'd0;
      repeat (2) @(negedge clk);
      chk("reset_outs", 32'({cmd_ack, cmd_nack, exu_no_commit, halted, run2halt,
                             halt2run, run_start, timeout, cause}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic issue(input bit hlt, input logic [N-1:0] m,
                        input logic [N-1:0] bsy, input int stall_at);
      exp_t e;
      logic [N-1:0] nw;
      bit done;
      e.ack = 1'b0;
      e.lat = 1;
      e.h2r = '0;
      if (m == '0) begin
         e.ack = 1'b0;
      end else if (hlt) begin
         nw = m & ~m_h;
         if (nw != '0) begin
            for (int i = 0; i < N; i++)
               if (nw[i]) begin
                  m_c[i] = 3'd1;
                  m_to[i] = bsy[i];
               end
            m_h = m_h | m;
            e.ack = ((m & m_to) == '0);
            e.lat = ((nw & bsy) != '0) ? T + 1 : 2;
         end
      end else if ((m & ~m_h) == '0) begin
         e.ack = 1'b1;
         e.h2r = m;
         m_h = m_h & ~m;
         m_to = m_to & ~m;
      end
      if (stall_at >= 0 && e.lat > stall_at) e.lat += 5;
      e.h = m_h;
      e.to = m_to;
      e.c = pk();
      @(negedge clk);
      cmd_req = 1'b1;
      cmd_halt = hlt;
      cmd_mask = m;
      exu_busy = bsy;
      e.t0 = cyc;
      q.push_back(e);
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         if (stall_at >= 0 && k == stall_at) begin
            clk_pipe_en = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("stall_no_r2h", 32'(run2halt), 0);
               chk("stall_no_resp", 32'(cmd_ack | cmd_nack), 0);
            end
            clk_pipe_en = 1'b1;
         end
         @(negedge clk);
         done = cmd_ack | cmd_nack;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout actual=no response expected=ack/nack");
         q.delete();
      end
      @(posedge clk);
      #1;
      cmd_req = 1'b0;
      exu_busy = '0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      do_reset();
      // Basic halt of both idle harts, then resume both
      issue(1'b1, 2'b11, 2'b00, -1);
      issue(1'b0, 2'b11, 2'b00, -1);
      // Run with a running hart in the mask is rejected, then succeeds
      issue(1'b1, 2'b01, 2'b00, -1);
      issue(1'b0, 2'b11, 2'b00, -1);
      issue(1'b1, 2'b10, 2'b00, -1);
      issue(1'b0, 2'b11, 2'b00, -1);
      // Already-halted halt, illegal mask
      issue(1'b1, 2'b01, 2'b00, -1);
      issue(1'b1, 2'b01, 2'b00, -1);
      issue(1'b1, 2'b00, 2'b00, -1);
      issue(1'b0, 2'b01, 2'b00, -1);
      // Forced halt on timeout, then again with a pipeline-enable stall
      issue(1'b1, 2'b01, 2'b01, -1);
      issue(1'b1, 2'b10, 2'b10, 10);
      issue(1'b0, 2'b11, 2'b00, -1);

      // Halt group: breakpoint on hart 1 drags hart 0 along
      do_reset();
      grp_en = 2'b11;
      dmode_brk_en = 2'b10;
      @(negedge clk);
      brkpt = 2'b10;
      #1;
      chk("grp_r2h_src", 32'(run2halt), 32'(2'b10));
      chk("grp_no_commit", 32'(exu_no_commit), 32'(2'b10));
      @(negedge clk);
      brkpt = 2'b00;
      #1;
      chk("grp_r2h_follow", 32'(run2halt), 32'(2'b01));
      chk("grp_nc_follow", 32'(exu_no_commit), 0);
      chk("grp_halted1", 32'(halted), 32'(2'b10));
      chk("grp_cause1", 32'(cause[5:3]), 3);
      @(negedge clk);
      chk("grp_halted_all", 32'(halted), 32'(2'b11));
      chk("grp_cause0", 32'(cause[2:0]), 5);

      // Reset exit and breakpoint together: reset cause wins
      do_reset();
      dmode_rst_en = 2'b01;
      dmode_brk_en = 2'b01;
      @(negedge clk);
      exu_init_pc = 2'b01;
      brkpt = 2'b01;
      #1;
      chk("prio_r2h", 32'(run2halt), 32'(2'b01));
      chk("prio_no_commit", 32'(exu_no_commit), 0);
      @(negedge clk);
      exu_init_pc = '0;
      brkpt = '0;
      chk("prio_cause", 32'(cause[2:0]), 2);

      // Randomized command traffic against the model
      do_reset();
      for (int n = 0; n < 40; n++) begin
         logic [N-1:0] b;
         for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, 3) == 0);
         issue(1'($urandom_range(0, 1)), N'($urandom_range(0, (1 << N) - 1)), b, -1);
      end

      // Asynchronous reset while a halt is pending
      do_reset();
      @(negedge clk);
      cmd_req = 1'b1;
      cmd_halt = 1'b1;
      cmd_mask = 2'b01;
      exu_busy = 2'b01;
      repeat (10) @(negedge clk);
      chk("pend_not_halted", 32'(halted), 0);
      rst_n = 1'b0;
      #1;
      chk("midreset_outs", 32'({cmd_ack, cmd_nack, exu_no_commit, halted, run2halt,
                                halt2run, run_start, timeout, cause}), 0);
      cmd_req = 1'b0;
      exu_busy = '0;
      m_h = '0;
      m_to = '0;
      for (int i = 0; i < N; i++) m_c[i] = 3'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      issue(1'b1, 2'b11, 2'b00, -1);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scr1_pipe_dbga_mh.md
Name: scr1_pipe_dbga_mh

Overview:
Multi-hart debug agent that generalises the single-hart run/halt control to N_HARTS channels. Each hart has its own halt/resume state machine, entry-cause capture and programmable timeout. A shared DBGC command port addresses any subset of harts by mask. An optional halt group stops all grouped harts when one halts on its own cause. The block sits between the DBGC and the per-hart EXU/IFU pipelines.

Parameters:
N_HARTS, 2, number of hart channels (1..8)
TIMEOUT, 64, halt-wait cycles before timeout; power of 2, at least 2
TO_W, $clog2(TIMEOUT), timeout counter width (derived, do not override)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clk_pipe_en  in  1  pipeline clock enable; gates every state update and pulse output
cmd_req  in  1  DBGC command valid; held until ack or nack
cmd_halt  in  1  1 = halt, 0 = run
cmd_mask  in  N_HARTS  target harts; all-zero mask is illegal
cmd_ack  out  1  command done, one-cycle pulse
cmd_nack  out  1  command rejected or timed out, one-cycle pulse
grp_en  in  N_HARTS  halt-group membership
dmode_rst_en / dmode_sstep_en / dmode_brk_en  in  N_HARTS each  per-hart debug entry enables
exu_busy  in  N_HARTS  hart cannot halt this cycle
instret  in  N_HARTS  instruction retired
brkpt  in  N_HARTS  breakpoint on current instruction
exu_init_pc  in  N_HARTS  reset exit
exu_no_commit  out  N_HARTS  breakpoint halt, suppress commit (combinational)
halted  out  N_HARTS  hart in debug halted state
run2halt / halt2run / run_start  out  N_HARTS each  transition pulses; run_start is registered halt2run
timeout  out  N_HARTS  hart timed out waiting to halt (sticky until next resume)
cause  out  3*N_HARTS  latched entry cause per hart

Behaviour:
- Reset values: all outputs 0. cause = 0. Timeout counters = TIMEOUT-1.
- Per-hart FSM: RUN -> PEND (halt requested by command or group) -> HALTED -> RUN.
  - RUN -> HALTED directly on an own cause when ~exu_busy.
  - PEND -> HALTED when ~exu_busy, or when the counter reaches 0 (forced halt, timeout=1).
  - The counter decrements once per enabled cycle in PEND and reloads TIMEOUT-1 on halt2run.
- Own causes: rst = dmode_rst_en & exu_init_pc; sstep = dmode_sstep_en & instret; brk = dmode_brk_en & brkpt.
- Cause codes: 0 none, 1 enforce, 2 rst, 3 brk, 4 sstep, 5 group.
- Cause priority on simultaneous events: rst > brk > sstep > enforce > group. Cause is latched on run2halt only.
- exu_no_commit[i] = brk cause active in that cycle.
- Halt command:
  - Accepted when cmd_req is first seen; masked RUN harts move to PEND and the command becomes pending internally.
  - When every masked hart is HALTED: ack if none of them timed out, else nack. Same cycle as the last run2halt plus 1.
  - If all masked harts are already halted on arrival: nack the following cycle (the earlier single-hart rule is kept).
- Run command:
  - If any masked hart is not HALTED: nack next cycle and no state change.
  - Otherwise all masked harts assert halt2run in the same cycle, and ack is in that same cycle.
- Halt group: a run2halt with an own cause on hart i where grp_en[i]=1 moves every other grp_en RUN hart to PEND on the next cycle, with cause 5. Group halts never produce ack or nack.
- cmd_req dropped while a command is pending: the command is abandoned, PEND harts continue to halt, no ack or nack.
- clk_pipe_en=0: state is frozen, pulses are suppressed, counters hold.
- Asynchronous reset mid-command: everything returns to reset values; the DBGC must reissue the command.
- Invariant: ack and nack are never asserted together.

Decomposition:
- Shared package scr1_dbga_mh_pkg:
  - cause enum type_scr1_dbga_cause_e (3 bits)
  - FSM enum type_scr1_dbga_hstate_e
  - cause priority function
- Sub-module scr1_pipe_dbga_hart: one hart's FSM, timeout counter and cause latch. Instantiated N_HARTS times by generate.
- The top level keeps command sequencing and group fan-out.

Test Plan:
- N_HARTS=2: halt with mask=11, both idle -> run2halt on both next cycle, ack 1 cycle later, cause=1,1.
- Halt mask=01, exu_busy[0] stuck 1, TIMEOUT=64 -> forced halt after 64 cycles, timeout[0]=1, nack.
- Run mask=11 with only hart 0 halted -> nack, halted stays 01. Then halt hart 1 and run 11 -> ack and halt2run=11 in the same cycle, run_start=11 next cycle.
- grp_en=11, brkpt[1] with dmode_brk_en[1] -> hart1 cause=3 and exu_no_commit[1]=1; hart0 halts one cycle later with cause=5; no ack.
- exu_init_pc and brkpt on the same cycle with both enables set -> cause=2 (rst wins).
- clk_pipe_en low for 5 cycles during PEND -> counter holds and no pulses; reset asserted mid-PEND -> all outputs 0.
